// File: rtl/fetch_unit_v2_if.sv
// Fetch unit bus bundle: decoder, memory controller and branch predictor links plus enable/redirect controls.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface fetch_unit_v2_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              rdy;
    logic              cache_full;
    logic [INST_W-1:0] inst_to_dec;
    logic [ADDR_W-1:0] pc_to_dec;
    logic              predicted_jump_to_dec;
    logic              flag_to_dec;
    logic [ADDR_W-1:0] pc_to_mc;
    logic              flag_to_mc;
    logic              drop_flag_to_mc;
    logic              flag_from_mc;
    logic [INST_W-1:0] inst_from_mc;
    logic [ADDR_W-1:0] query_pc_to_pdc;
    logic [INST_W-1:0] query_inst_to_pdc;
    logic              predicted_jump_flag_from_pdc;
    logic [ADDR_W-1:0] predicted_target_from_pdc;
    logic              redirect_flag;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inval_flag;

    modport master (
        input  rdy, cache_full, flag_from_mc, inst_from_mc,
               predicted_jump_flag_from_pdc, predicted_target_from_pdc,
               redirect_flag, redirect_pc, inval_flag,
        output inst_to_dec, pc_to_dec, predicted_jump_to_dec, flag_to_dec,
               pc_to_mc, flag_to_mc, drop_flag_to_mc,
               query_pc_to_pdc, query_inst_to_pdc
    );

    modport slave (
        output rdy, cache_full, flag_from_mc, inst_from_mc,
               predicted_jump_flag_from_pdc, predicted_target_from_pdc,
               redirect_flag, redirect_pc, inval_flag,
        input  inst_to_dec, pc_to_dec, predicted_jump_to_dec, flag_to_dec,
               pc_to_mc, flag_to_mc, drop_flag_to_mc,
               query_pc_to_pdc, query_inst_to_pdc
    );
endinterface

// File: rtl/fetch_unit_v2.sv
// Instruction fetch with a direct-mapped multi-word-line I-cache; one instruction per cycle on a hit.
// Latency: PC to flag_to_dec one cycle; cache_full or rdy low stall fetch with pc held.
module fetch_unit_v2 #(
    parameter int              ADDR_W     = 32,
    parameter int              INST_W     = 32,
    parameter int              SETS       = 64,
    parameter int              LINE_WORDS = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst,
    fetch_unit_v2_if.master bus
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_W - IW - OW - 2;
    localparam int CW = (OW > 0) ? OW : 1;
    localparam int DW = IW + OW;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [SETS-1:0]     valid;
    logic [TW-1:0]       tag_store [SETS];
    logic [INST_W-1:0]   data_store [SETS*LINE_WORDS];
    logic [CW-1:0]       word_cnt;
    logic [IW-1:0]       refill_index;
    logic [TW-1:0]       refill_tag;

    logic [IW-1:0]       cur_index;
    logic [TW-1:0]       cur_tag;
    logic [DW-1:0]       rd_addr;
    logic [DW-1:0]       wr_addr;
    logic                hit;
    logic                issue;
    logic                last_word;
    logic                fill_en;

    assign cur_index = pc[OW+2 +: IW];
    assign cur_tag   = pc[ADDR_W-1 -: TW];
    assign rd_addr   = pc[2 +: DW];
    assign wr_addr   = (DW'(refill_index) << OW) | DW'(word_cnt);
    assign hit       = valid[cur_index] && (tag_store[cur_index] == cur_tag);
    assign issue     = hit && !bus.cache_full;
    assign last_word = (word_cnt == CW'(LINE_WORDS - 1));

    // Refill writes are suppressed on a redirect/inval cycle so an aborted line never completes.
    assign fill_en = bus.rdy && !bus.redirect_flag && !bus.inval_flag &&
                     (state == REFILL) && bus.flag_from_mc;

    assign bus.query_pc_to_pdc   = pc;
    assign bus.query_inst_to_pdc = hit ? data_store[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_store[wr_addr] <= bus.inst_from_mc;
            if (last_word)
                tag_store[refill_index] <= refill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= IDLE;
            pc                        <= RESET_PC;
            valid                     <= '0;
            word_cnt                  <= '0;
            refill_index              <= '0;
            refill_tag                <= '0;
            bus.inst_to_dec           <= '0;
            bus.pc_to_dec             <= '0;
            bus.predicted_jump_to_dec <= 1'b0;
            bus.flag_to_dec           <= 1'b0;
            bus.pc_to_mc              <= '0;
            bus.flag_to_mc            <= 1'b0;
            bus.drop_flag_to_mc       <= 1'b0;
        end else if (bus.rdy) begin
            bus.flag_to_dec     <= 1'b0;
            bus.flag_to_mc      <= 1'b0;
            bus.drop_flag_to_mc <= 1'b0;
            if (bus.redirect_flag || bus.inval_flag) begin
                if (bus.redirect_flag)
                    pc <= bus.redirect_pc;
                if (bus.inval_flag)
                    valid <= '0;
                if (state == REFILL) begin
                    bus.drop_flag_to_mc <= 1'b1;
                    word_cnt            <= '0;
                    state               <= IDLE;
                end
            end else begin
                if (issue) begin
                    bus.inst_to_dec           <= data_store[rd_addr];
                    bus.pc_to_dec             <= pc;
                    bus.flag_to_dec           <= 1'b1;
                    bus.predicted_jump_to_dec <= bus.predicted_jump_flag_from_pdc;
                    pc <= bus.predicted_jump_flag_from_pdc ? bus.predicted_target_from_pdc
                                                           : pc + ADDR_W'(4);
                end
                case (state)
                    IDLE: begin
                        if (!hit) begin
                            bus.pc_to_mc      <= {cur_tag, cur_index, {(OW+2){1'b0}}};
                            bus.flag_to_mc    <= 1'b1;
                            valid[cur_index]  <= 1'b0;
                            word_cnt          <= '0;
                            refill_index      <= cur_index;
                            refill_tag        <= cur_tag;
                            state             <= REFILL;
                        end
                    end
                    REFILL: begin
                        if (bus.flag_from_mc) begin
                            if (last_word) begin
                                valid[refill_index] <= 1'b1;
                                word_cnt            <= '0;
                                state               <= IDLE;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit_v2.sv
// Directed bench for fetch_unit_v2: refill, issue, prediction, stall, redirect abort, rdy hold, invalidate.
module tb_fetch_unit_v2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_v2_if #(.ADDR_W(32), .INST_W(32)) bus ();

    fetch_unit_v2 #(
        .ADDR_W(32), .INST_W(32), .SETS(64), .LINE_WORDS(4), .RESET_PC(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] word);
        bus.flag_from_mc = 1'b1;
        bus.inst_from_mc = word;
        step();
        bus.flag_from_mc = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_vld"},  64'(bus.flag_to_dec), 64'd1);
        check({tag, "_pc"},   64'(bus.pc_to_dec),   64'(pc));
        check({tag, "_inst"}, 64'(bus.inst_to_dec), 64'(inst));
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        check({tag, "_vld"},  64'(bus.flag_to_mc), 64'd1);
        check({tag, "_addr"}, 64'(bus.pc_to_mc),   64'(addr));
    endtask

    initial begin
        bus.rdy = 1'b1;
        bus.cache_full = 1'b0;
        bus.flag_from_mc = 1'b0;
        bus.inst_from_mc = '0;
        bus.predicted_jump_flag_from_pdc = 1'b0;
        bus.predicted_target_from_pdc = '0;
        bus.redirect_flag = 1'b0;
        bus.redirect_pc = '0;
        bus.inval_flag = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_dec_vld", 64'(bus.flag_to_dec),     64'd0);
        check("rst_mc_vld",  64'(bus.flag_to_mc),      64'd0);
        check("rst_drop",    64'(bus.drop_flag_to_mc), 64'd0);
        check("rst_pc_dec",  64'(bus.pc_to_dec),       64'd0);
        check("rst_pc_mc",   64'(bus.pc_to_mc),        64'd0);
        check("rst_qpc",     64'(bus.query_pc_to_pdc), 64'd0);
        check("rst_qinst",   64'(bus.query_inst_to_pdc), 64'd0);
        rst = 1'b1;

        // Cold miss at 0x0 and line refill
        step();
        expect_req("req0", 32'h0);
        feed(32'h13);
        check("req0_pulse", 64'(bus.flag_to_mc), 64'd0);
        feed(32'h93);
        feed(32'h113);
        feed(32'h193);
        check("fill0_qinst", 64'(bus.query_inst_to_pdc), 64'h13);
        step(); expect_issue("iss0", 32'h0, 32'h13);
        step(); expect_issue("iss4", 32'h4, 32'h93);
        step(); expect_issue("iss8", 32'h8, 32'h113);
        step(); expect_issue("issc", 32'hC, 32'h193);
        check("issc_qpc", 64'(bus.query_pc_to_pdc), 64'h10);

        // Next line misses; abort after two words via redirect
        step();
        expect_req("req10", 32'h10);
        check("req10_novld", 64'(bus.flag_to_dec), 64'd0);
        feed(32'h213);
        feed(32'h293);
        bus.redirect_flag = 1'b1;
        bus.redirect_pc   = 32'h100;
        step();
        check("redir_drop", 64'(bus.drop_flag_to_mc), 64'd1);
        check("redir_qpc",  64'(bus.query_pc_to_pdc), 64'h100);
        bus.redirect_flag = 1'b0;
        step();
        check("drop_pulse", 64'(bus.drop_flag_to_mc), 64'd0);
        expect_req("req100", 32'h100);
        feed(32'h2013);
        feed(32'h2093);
        feed(32'h2113);
        feed(32'h2193);

        // Decoder back-pressure holds pc
        bus.cache_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_vld", 64'(bus.flag_to_dec),     64'd0);
            check("full_qpc", 64'(bus.query_pc_to_pdc), 64'h100);
        end
        bus.cache_full = 1'b0;
        step(); expect_issue("iss100", 32'h100, 32'h2013);

        // Predicted-taken branch at 0x8
        bus.redirect_flag = 1'b1;
        bus.redirect_pc   = 32'h8;
        step();
        check("redir8_vld", 64'(bus.flag_to_dec), 64'd0);
        check("redir8_nodrop", 64'(bus.drop_flag_to_mc), 64'd0);
        bus.redirect_flag = 1'b0;
        bus.predicted_jump_flag_from_pdc = 1'b1;
        bus.predicted_target_from_pdc    = 32'h40;
        step();
        expect_issue("pred8", 32'h8, 32'h113);
        check("pred8_taken", 64'(bus.predicted_jump_to_dec), 64'd1);
        check("pred8_qpc",   64'(bus.query_pc_to_pdc),       64'h40);
        bus.predicted_jump_flag_from_pdc = 1'b0;
        step();
        expect_req("req40", 32'h40);

        // rdy low mid-refill: everything holds, even a redirect is ignored
        feed(32'h813);
        feed(32'h893);
        bus.rdy = 1'b0;
        bus.redirect_flag = 1'b1;
        bus.redirect_pc   = 32'h300;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_qpc",  64'(bus.query_pc_to_pdc), 64'h40);
            check("hold_mc",   64'(bus.flag_to_mc),      64'd0);
            check("hold_drop", 64'(bus.drop_flag_to_mc), 64'd0);
            check("hold_pcmc", 64'(bus.pc_to_mc),        64'h40);
            check("hold_pcd",  64'(bus.pc_to_dec),       64'h8);
        end
        bus.rdy = 1'b1;
        bus.redirect_flag = 1'b0;
        feed(32'h913);
        check("hold_nohit", 64'(bus.query_inst_to_pdc), 64'h0);
        feed(32'h993);
        check("fill40_qinst", 64'(bus.query_inst_to_pdc), 64'h813);
        step(); expect_issue("iss40", 32'h40, 32'h813);
        step(); expect_issue("iss44", 32'h44, 32'h893);
        step(); expect_issue("iss48", 32'h48, 32'h913);

        // Invalidate, then re-fetch 0x0 must miss
        bus.inval_flag = 1'b1;
        step();
        check("inval_vld",   64'(bus.flag_to_dec),       64'd0);
        check("inval_qpc",   64'(bus.query_pc_to_pdc),   64'h4C);
        check("inval_qinst", 64'(bus.query_inst_to_pdc), 64'h0);
        bus.inval_flag = 1'b0;
        step();
        expect_req("req4c", 32'h40);
        bus.redirect_flag = 1'b1;
        bus.redirect_pc   = 32'h0;
        step();
        check("redir0_drop", 64'(bus.drop_flag_to_mc), 64'd1);
        bus.redirect_flag = 1'b0;
        step();
        expect_req("req0b", 32'h0);
        check("req0b_qinst", 64'(bus.query_inst_to_pdc), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit_v2.md
Name: fetch_unit_v2

Overview:
- Parametrised instruction fetch unit with a direct-mapped, multi-word-line instruction cache.
- Sits between the memory controller and the decoder.
- Supplies one instruction per cycle on a hit and steers the PC using the branch predictor's direction and target.
- Adds line refills of LINE_WORDS words, redirect on mispredict with refill abort, and whole-cache invalidation.

Parameters:
- ADDR_W, 32, address width.
- INST_W, 32, instruction width.
- SETS, 64, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, instructions per line; power of two, at least 1.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global enable; when low, all registers hold.
- cache_full  in  1  decoder/queue cannot accept an instruction.
- inst_to_dec  out  INST_W  fetched instruction.
- pc_to_dec  out  ADDR_W  PC of inst_to_dec.
- predicted_jump_to_dec  out  1  predictor taken flag for inst_to_dec.
- flag_to_dec  out  1  inst_to_dec valid this cycle.
- pc_to_mc  out  ADDR_W  line base address of the refill request.
- flag_to_mc  out  1  one-cycle refill request pulse.
- drop_flag_to_mc  out  1  one-cycle abort pulse for the outstanding refill.
- flag_from_mc  in  1  inst_from_mc carries the next word of the line.
- inst_from_mc  in  INST_W  refill word; words arrive in ascending address order.
- query_pc_to_pdc  out  ADDR_W  current PC (combinational).
- query_inst_to_pdc  out  INST_W  cached instruction at PC, or 0 on a miss (combinational).
- predicted_jump_flag_from_pdc  in  1  predictor says taken.
- predicted_target_from_pdc  in  ADDR_W  predicted target address.
- redirect_flag  in  1  mispredict or exception: fetch restarts at redirect_pc.
- redirect_pc  in  ADDR_W  restart address.
- inval_flag  in  1  invalidate the whole cache (fence.i).

Behaviour:
- Address split:
  - offset = pc[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
  - pc[1:0] is ignored.
- Storage:
  - valid[SETS]
  - tag_store[SETS]
  - data_store[SETS*LINE_WORDS], addressed {index,offset}
- hit = valid[index] && tag_store[index]==tag (combinational on pc).
- Reset (rst low, asynchronous):
  - pc=RESET_PC; all valid bits 0; state=IDLE; word_cnt=0.
  - flag_to_dec, flag_to_mc and drop_flag_to_mc are 0.
  - inst_to_dec, pc_to_dec, pc_to_mc and predicted_jump_to_dec are 0.
  - tag_store and data_store need not be reset.
- Pulse outputs:
  - flag_to_dec, flag_to_mc and drop_flag_to_mc default to 0 every enabled cycle unless set below.
- Priority (rdy high), highest first:
  1. redirect_flag:
     - pc<=redirect_pc; flag_to_dec<=0.
     - If state=REFILL: drop_flag_to_mc<=1, state<=IDLE, and that line stays invalid.
  2. inval_flag:
     - All valid<=0; flag_to_dec<=0.
     - An outstanding refill is dropped as in 1.
     - inval has no effect on pc.
  3. Normal operation.
- Issue, when hit && !cache_full:
  - inst_to_dec<=cached word; pc_to_dec<=pc; flag_to_dec<=1.
  - predicted_jump_to_dec<=predicted_jump_flag_from_pdc.
  - pc<= predicted ? predicted_target_from_pdc : pc+4.
  - Latency: one cycle from PC to flag_to_dec.
  - Otherwise flag_to_dec<=0 and pc holds.
- FSM state IDLE:
  - If !hit, or if hit and the issue moves pc into a different line whose index is currently invalid: no prefetch; only the current-pc miss triggers a refill.
  - On !hit (and no redirect/inval): pc_to_mc<={tag,index,0s}; flag_to_mc<=1; valid[index]<=0; word_cnt<=0; latch refill index/tag; state<=REFILL.
- FSM state REFILL:
  - On each flag_from_mc: data_store[{refill_index,word_cnt}]<=inst_from_mc; word_cnt<=word_cnt+1.
  - On the word with word_cnt==LINE_WORDS-1: tag_store<=refill tag; valid[refill_index]<=1; word_cnt<=0; state<=IDLE.
  - The refilled line is usable for a hit the cycle after.
- Hits to other (valid) lines continue to issue during REFILL.
- flag_from_mc while IDLE is ignored.
- word_cnt wraps only via the completion reset.
- A simultaneous final refill word and redirect: the redirect wins and the line is not validated.
- PC arithmetic is modulo 2^ADDR_W.
- rdy low: nothing changes, including pulses (held outputs stay as last driven).

Test Plan:
1. Reset release, LINE_WORDS=4, memory returns 0x13,0x93,0x113,0x193 for 0x0..0xC -> flag_to_mc=1 with pc_to_mc=0x0 one cycle after release; after 4 words, flag_to_dec pulses on 4 consecutive cycles with pc_to_dec 0x0,0x4,0x8,0xC and matching insts.
2. Hit at pc=0x8 with predictor taken, target 0x40 -> pc_to_dec=0x8, predicted_jump_to_dec=1; next request pc_to_mc=0x40.
3. cache_full held high 3 cycles during hits -> flag_to_dec=0 and pc unchanged; resumes at the same PC when low.
4. redirect_flag with redirect_pc=0x100 after 2 of 4 refill words -> drop_flag_to_mc=1 for one cycle; the old line is not valid; a new request goes out for 0x100.
5. inval_flag after the line at 0x0 is filled, then fetch 0x0 -> miss, new refill request to 0x0.
6. rdy low for 5 cycles mid-refill with flag_from_mc low -> all outputs and word_cnt unchanged; completion proceeds normally after rdy returns.
